// File: rtl/rob_mw_if.sv
// rtl/rob_mw_if.sv - dispatch/complete/retire/recovery bundle for the reorder buffer
// Purpose: groups every handshake and bus signal of rob_mw into one interface.
// Ports (slave = ROB side):
//   in : disp_valid, disp_stall, disp_regdest, disp_store, disp_rd, disp_pr_old, disp_pr_new,
//        cmp_valid, cmp_rob, cmp_mispredict, cmp_target
//   out: disp_rob, ret0_*/ret1_* (valid, rob, pr_old, regdest, store), full, empty, count,
//        recover, flush_rob, flush_rd, flush_pr_old, flush_pr_new, flush_regdest,
//        redirect, redirect_addr
interface rob_mw_if #(
  parameter int DEPTH = 16,
  parameter int PR_W  = 6,
  parameter int AR_W  = 5
);
  localparam int IDX_W = $clog2(DEPTH);

  logic             disp_valid;
  logic             disp_stall;
  logic             disp_regdest;
  logic             disp_store;
  logic [AR_W-1:0]  disp_rd;
  logic [PR_W-1:0]  disp_pr_old;
  logic [PR_W-1:0]  disp_pr_new;
  logic [IDX_W-1:0] disp_rob;

  logic             cmp_valid;
  logic [IDX_W-1:0] cmp_rob;
  logic             cmp_mispredict;
  logic [31:0]      cmp_target;

  logic             ret0_valid;
  logic [IDX_W-1:0] ret0_rob;
  logic [PR_W-1:0]  ret0_pr_old;
  logic             ret0_regdest;
  logic             ret0_store;
  logic             ret1_valid;
  logic [IDX_W-1:0] ret1_rob;
  logic [PR_W-1:0]  ret1_pr_old;
  logic             ret1_regdest;
  logic             ret1_store;

  logic             full;
  logic             empty;
  logic [IDX_W:0]   count;

  logic             recover;
  logic [IDX_W-1:0] flush_rob;
  logic [AR_W-1:0]  flush_rd;
  logic [PR_W-1:0]  flush_pr_old;
  logic [PR_W-1:0]  flush_pr_new;
  logic             flush_regdest;

  logic             redirect;
  logic [31:0]      redirect_addr;

  modport master (
    output disp_valid, disp_stall, disp_regdest, disp_store, disp_rd, disp_pr_old, disp_pr_new,
    output cmp_valid, cmp_rob, cmp_mispredict, cmp_target,
    input  disp_rob,
    input  ret0_valid, ret0_rob, ret0_pr_old, ret0_regdest, ret0_store,
    input  ret1_valid, ret1_rob, ret1_pr_old, ret1_regdest, ret1_store,
    input  full, empty, count,
    input  recover, flush_rob, flush_rd, flush_pr_old, flush_pr_new, flush_regdest,
    input  redirect, redirect_addr
  );

  modport slave (
    input  disp_valid, disp_stall, disp_regdest, disp_store, disp_rd, disp_pr_old, disp_pr_new,
    input  cmp_valid, cmp_rob, cmp_mispredict, cmp_target,
    output disp_rob,
    output ret0_valid, ret0_rob, ret0_pr_old, ret0_regdest, ret0_store,
    output ret1_valid, ret1_rob, ret1_pr_old, ret1_regdest, ret1_store,
    output full, empty, count,
    output recover, flush_rob, flush_rd, flush_pr_old, flush_pr_new, flush_regdest,
    output redirect, redirect_addr
  );
endinterface

// File: rtl/rob_mw.sv
// rtl/rob_mw.sv - reorder buffer with dual in-order retire and tail-walk branch recovery
// Purpose: allocates one entry per cycle at the tail, marks completions, retires up to two
//   completed entries per cycle from the head, and on a mispredict walks the tail back one
//   entry per cycle (exposing each flushed entry) before a one-cycle redirect.
// Ports: clk (rising edge), rst (asynchronous, active low), bus (rob_mw_if.slave).
module rob_mw #(
  parameter int DEPTH = 16,
  parameter int PR_W  = 6,
  parameter int AR_W  = 5
) (
  input logic     clk,
  input logic     rst,
  rob_mw_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] TWO  = IDX_W'(2);

  typedef enum logic [1:0] {S_IDLE, S_REC, S_REDIR} state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   head, tail, tail_next;
  logic [CNT_W-1:0]   count, count_next;
  logic [DEPTH-1:0]   complete;
  logic [IDX_W-1:0]   br_rob, br_next;
  logic [31:0]        addr, addr_next;

  logic [DEPTH-1:0]   e_regdest;
  logic [DEPTH-1:0]   e_store;
  logic [AR_W-1:0]    e_rd     [DEPTH];
  logic [PR_W-1:0]    e_pr_old [DEPTH];
  logic [PR_W-1:0]    e_pr_new [DEPTH];

  logic               full, empty;
  logic               mis;
  logic               alloc, ret0, ret1, dec;
  logic               recover, redirect;
  logic [IDX_W-1:0]   head_p1, tail_m1, tail_m2;
  logic [IDX_W-1:0]   age_cmp, age_br;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign mis     = bus.cmp_valid & bus.cmp_mispredict;
  assign head_p1 = head + ONE;
  assign tail_m1 = tail - ONE;
  assign tail_m2 = tail - TWO;
  // Ages are measured from head, which is frozen while recovering.
  assign age_cmp = bus.cmp_rob - head;
  assign age_br  = br_rob - head;

  always_comb begin
    state_next = state;
    tail_next  = tail;
    br_next    = br_rob;
    addr_next  = addr;
    alloc      = 1'b0;
    ret0       = 1'b0;
    ret1       = 1'b0;
    dec        = 1'b0;
    recover    = 1'b0;
    redirect   = 1'b0;
    case (state)
      S_IDLE: begin
        if (mis) begin
          // Latching cycle: no allocate and no retire.
          br_next    = bus.cmp_rob;
          addr_next  = bus.cmp_target;
          state_next = (bus.cmp_rob == tail_m1) ? S_REDIR : S_REC;
        end else begin
          alloc = bus.disp_valid & ~full & ~bus.disp_stall;
          ret0  = ~empty & complete[head];
          // At most one store may leave per cycle.
          ret1  = ret0 & (count >= CNT_W'(2)) & complete[head_p1]
                  & ~(e_store[head] & e_store[head_p1]);
          if (alloc) tail_next = tail + ONE;
        end
      end
      S_REC: begin
        recover   = 1'b1;
        dec       = 1'b1;
        tail_next = tail_m1;
        // Only an older branch can take over; its entry has not been flushed yet.
        if (mis && (age_cmp < age_br)) begin
          br_next   = bus.cmp_rob;
          addr_next = bus.cmp_target;
        end
        if (tail_m2 == br_next) state_next = S_REDIR;
      end
      S_REDIR: begin
        redirect   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign count_next = count + CNT_W'(alloc) - CNT_W'(ret0) - CNT_W'(ret1) - CNT_W'(dec);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      complete <= '0;
      br_rob   <= '0;
      addr     <= '0;
    end else begin
      state  <= state_next;
      tail   <= tail_next;
      count  <= count_next;
      br_rob <= br_next;
      addr   <= addr_next;
      head   <= head + (ret1 ? TWO : (ret0 ? ONE : '0));
      if (bus.cmp_valid) complete[bus.cmp_rob] <= 1'b1;
      // Allocation to the same index overrides a stale completion.
      if (alloc) complete[tail] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) begin
      e_regdest[tail] <= bus.disp_regdest;
      e_store[tail]   <= bus.disp_store;
      e_rd[tail]      <= bus.disp_rd;
      e_pr_old[tail]  <= bus.disp_pr_old;
      e_pr_new[tail]  <= bus.disp_pr_new;
    end
  end

  assign bus.disp_rob      = tail;
  assign bus.full          = full;
  assign bus.empty         = empty;
  assign bus.count         = count;

  assign bus.ret0_valid    = ret0;
  assign bus.ret0_rob      = head;
  assign bus.ret0_pr_old   = e_pr_old[head];
  assign bus.ret0_regdest  = e_regdest[head];
  assign bus.ret0_store    = e_store[head];
  assign bus.ret1_valid    = ret1;
  assign bus.ret1_rob      = head_p1;
  assign bus.ret1_pr_old   = e_pr_old[head_p1];
  assign bus.ret1_regdest  = e_regdest[head_p1];
  assign bus.ret1_store    = e_store[head_p1];

  assign bus.recover       = recover;
  assign bus.flush_rob     = tail_m1;
  assign bus.flush_rd      = e_rd[tail_m1];
  assign bus.flush_pr_old  = e_pr_old[tail_m1];
  assign bus.flush_pr_new  = e_pr_new[tail_m1];
  assign bus.flush_regdest = e_regdest[tail_m1];

  assign bus.redirect      = redirect;
  assign bus.redirect_addr = addr;
endmodule

// File: tb/tb_rob_mw.sv
// tb/tb_rob_mw.sv - directed self-checking bench for rob_mw
// Purpose: linear directed sequence covering reset, fill/full, dual retire, store pairing,
//   single and nested recovery, wrapped recovery and asynchronous reset mid-recovery.
// Ports: none (top-level bench).
module tb_rob_mw;
  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  rob_mw_if #(.DEPTH(16), .PR_W(6), .AR_W(5)) bus ();
  rob_mw    #(.DEPTH(16), .PR_W(6), .AR_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_in();
    bus.disp_valid     = 1'b0;
    bus.disp_stall     = 1'b0;
    bus.disp_regdest   = 1'b0;
    bus.disp_store     = 1'b0;
    bus.disp_rd        = '0;
    bus.disp_pr_old    = '0;
    bus.disp_pr_new    = '0;
    bus.cmp_valid      = 1'b0;
    bus.cmp_rob        = '0;
    bus.cmp_mispredict = 1'b0;
    bus.cmp_target     = '0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic put(input int i, input bit st);
    bus.disp_valid   = 1'b1;
    bus.disp_regdest = 1'b1;
    bus.disp_store   = st;
    bus.disp_rd      = 5'(i);
    bus.disp_pr_old  = 6'(i);
    bus.disp_pr_new  = 6'(i + 32);
  endtask

  task automatic cmp(input int r);
    bus.cmp_valid      = 1'b1;
    bus.cmp_rob        = 4'(r);
    bus.cmp_mispredict = 1'b0;
  endtask

  task automatic mis(input int r, input logic [31:0] tgt);
    bus.cmp_valid      = 1'b1;
    bus.cmp_rob        = 4'(r);
    bus.cmp_mispredict = 1'b1;
    bus.cmp_target     = tgt;
  endtask

  initial begin
    idle_in();
    rst = 1'b0;
    tick();
    tick();
    settle();
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_disp_rob", 32'(bus.disp_rob), 0);
    chk("rst_ret0", 32'(bus.ret0_valid), 0);
    chk("rst_ret1", 32'(bus.ret1_valid), 0);
    chk("rst_recover", 32'(bus.recover), 0);
    chk("rst_redirect", 32'(bus.redirect), 0);
    chk("rst_redir_addr", bus.redirect_addr, 0);
    rst = 1'b1;
    tick();

    // Fill all 16 entries, then a 17th request is refused.
    for (int i = 0; i < 16; i++) begin
      put(i, 1'b0);
      settle();
      chk("fill_disp_rob", 32'(bus.disp_rob), i);
      tick();
    end
    idle_in();
    settle();
    chk("fill_full", 32'(bus.full), 1);
    chk("fill_count", 32'(bus.count), 16);
    chk("fill_wrap_rob", 32'(bus.disp_rob), 0);
    put(16, 1'b0);
    tick();
    idle_in();
    settle();
    chk("over_count", 32'(bus.count), 16);
    chk("over_disp_rob", 32'(bus.disp_rob), 0);

    // Dual retire of four completed entries.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      put(i, 1'b0);
      tick();
    end
    idle_in();
    cmp(3); tick();
    cmp(2); tick();
    cmp(1); tick();
    cmp(0);
    settle();
    chk("dual_pre_ret0", 32'(bus.ret0_valid), 0);
    tick();
    idle_in();
    settle();
    chk("dual_a_ret0", 32'(bus.ret0_valid), 1);
    chk("dual_a_rob0", 32'(bus.ret0_rob), 0);
    chk("dual_a_ret1", 32'(bus.ret1_valid), 1);
    chk("dual_a_rob1", 32'(bus.ret1_rob), 1);
    chk("dual_a_pr_old", 32'(bus.ret1_pr_old), 1);
    chk("dual_a_count", 32'(bus.count), 4);
    tick();
    settle();
    chk("dual_b_rob0", 32'(bus.ret0_rob), 2);
    chk("dual_b_rob1", 32'(bus.ret1_rob), 3);
    chk("dual_b_ret1", 32'(bus.ret1_valid), 1);
    chk("dual_b_count", 32'(bus.count), 2);
    tick();
    settle();
    chk("dual_c_count", 32'(bus.count), 0);
    chk("dual_c_empty", 32'(bus.empty), 1);
    chk("dual_c_ret0", 32'(bus.ret0_valid), 0);

    // Two adjacent stores retire one per cycle.
    do_reset();
    put(0, 1'b1); tick();
    put(1, 1'b1); tick();
    idle_in();
    cmp(1); tick();
    cmp(0); tick();
    idle_in();
    settle();
    chk("st_a_ret0", 32'(bus.ret0_valid), 1);
    chk("st_a_rob0", 32'(bus.ret0_rob), 0);
    chk("st_a_store", 32'(bus.ret0_store), 1);
    chk("st_a_ret1", 32'(bus.ret1_valid), 0);
    tick();
    settle();
    chk("st_b_ret0", 32'(bus.ret0_valid), 1);
    chk("st_b_rob0", 32'(bus.ret0_rob), 1);
    chk("st_b_count", 32'(bus.count), 1);
    tick();
    settle();
    chk("st_c_empty", 32'(bus.empty), 1);

    // Mispredict on rob 2 with 0..5 allocated; a dispatch that cycle is dropped.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      put(i, 1'b0);
      tick();
    end
    idle_in();
    mis(2, 32'h400);
    put(6, 1'b0);
    tick();
    idle_in();
    settle();
    chk("rec1_recover", 32'(bus.recover), 1);
    chk("rec1_flush_rob", 32'(bus.flush_rob), 5);
    chk("rec1_flush_rd", 32'(bus.flush_rd), 5);
    chk("rec1_flush_new", 32'(bus.flush_pr_new), 37);
    chk("rec1_count", 32'(bus.count), 6);
    tick();
    settle();
    chk("rec2_flush_rob", 32'(bus.flush_rob), 4);
    tick();
    settle();
    chk("rec3_flush_rob", 32'(bus.flush_rob), 3);
    chk("rec3_recover", 32'(bus.recover), 1);
    tick();
    settle();
    chk("redir_valid", 32'(bus.redirect), 1);
    chk("redir_addr", bus.redirect_addr, 32'h400);
    chk("redir_recover", 32'(bus.recover), 0);
    chk("redir_tail", 32'(bus.disp_rob), 3);
    tick();
    settle();
    chk("post_redir", 32'(bus.redirect), 0);
    chk("post_count", 32'(bus.count), 3);

    // Older mispredict arriving mid-recovery takes over; a younger one is ignored.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      put(i, 1'b0);
      tick();
    end
    idle_in();
    mis(2, 32'h400);
    tick();
    idle_in();
    mis(1, 32'h800);
    settle();
    chk("nest1_flush_rob", 32'(bus.flush_rob), 5);
    tick();
    idle_in();
    mis(4, 32'hc00);
    settle();
    chk("nest2_flush_rob", 32'(bus.flush_rob), 4);
    tick();
    idle_in();
    settle();
    chk("nest3_flush_rob", 32'(bus.flush_rob), 3);
    tick();
    settle();
    chk("nest4_flush_rob", 32'(bus.flush_rob), 2);
    chk("nest4_recover", 32'(bus.recover), 1);
    tick();
    settle();
    chk("nest_redir", 32'(bus.redirect), 1);
    chk("nest_addr", bus.redirect_addr, 32'h800);
    chk("nest_tail", 32'(bus.disp_rob), 2);
    tick();

    // Move head to 14, wrap tail to 2, recover from rob 15, reset mid-recovery.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      put(i, 1'b0);
      tick();
    end
    idle_in();
    for (int i = 0; i < 14; i++) begin
      cmp(i);
      tick();
    end
    idle_in();
    begin
      int n = 0;
      settle();
      while (bus.empty !== 1'b1 && n < 20) begin
        tick();
        settle();
        n++;
      end
      chk("drain_empty", 32'(bus.empty), 1);
    end
    chk("drain_tail", 32'(bus.disp_rob), 14);
    tick();
    for (int i = 14; i < 18; i++) begin
      put(i, 1'b0);
      tick();
    end
    idle_in();
    settle();
    chk("wrap_tail", 32'(bus.disp_rob), 2);
    chk("wrap_count", 32'(bus.count), 4);
    mis(15, 32'h123);
    tick();
    idle_in();
    settle();
    chk("wrap1_recover", 32'(bus.recover), 1);
    chk("wrap1_flush_rob", 32'(bus.flush_rob), 1);
    chk("wrap1_count", 32'(bus.count), 4);
    tick();
    settle();
    chk("wrap2_flush_rob", 32'(bus.flush_rob), 0);
    chk("wrap2_recover", 32'(bus.recover), 1);
    rst = 1'b0;
    #1;
    chk("arst_recover", 32'(bus.recover), 0);
    chk("arst_empty", 32'(bus.empty), 1);
    chk("arst_count", 32'(bus.count), 0);
    chk("arst_tail", 32'(bus.disp_rob), 0);
    tick();
    rst = 1'b1;
    tick();
    settle();
    chk("arst_after_empty", 32'(bus.empty), 1);
    chk("arst_after_redir", 32'(bus.redirect), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
